ahblite_apb_bridge: RTL and testbench
=====================================

# ahblite_apb_bridge

AHB-Lite slave that converts single AHB-Lite transfers into APB3/APB4 accesses. It sits on one peripheral port of the AHB-Lite interconnect and consumes that port's HSEL/address/control/HWDATA/HREADY. It returns HREADYOUT/HRDATA/HRESP to the slave multiplexer. It lets low-speed register peripherals (UART, GPIO, timers) sit behind a single interconnect slot.

## Interface
Parameters:
- PADDR_WIDTH, 16: width of PADDR, taken from HADDR[PADDR_WIDTH-1:0].
- TIMEOUT, 255: maximum ACCESS cycles with PREADY low before the bridge forces an error. 0 disables the timeout.

Ports:
- HCLK  in  1  clock, single domain.
- HRESET  in  1  asynchronous, active-high reset.
- HSEL  in  1  slave select from the interconnect decoder.
- HADDR  in  32  address.
- HTRANS  in  2  transfer type.
- HSIZE  in  3  transfer size.
- HWRITE  in  1  write when 1.
- HWDATA  in  32  write data, valid in the data phase.
- HREADY  in  1  bus-wide ready from the slave multiplexer.
- HREADYOUT  out  1  this slave's ready.
- HRDATA  out  32  read data.
- HRESP  out  1  0 = OKAY, 1 = ERROR.
- PADDR  out  PADDR_WIDTH  APB address.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB direction.
- PWDATA  out  32  APB write data.
- PSTRB  out  4  APB byte strobes.
- PRDATA  in  32  APB read data.
- PREADY  in  1  APB ready.
- PSLVERR  in  1  APB error.

## Operation
- Accept a transfer when HSEL & HTRANS[1] & HREADY. IDLE and BUSY transfers get a zero-wait OKAY.
- On accept, register HADDR[PADDR_WIDTH-1:0], HWRITE, HSIZE and HADDR[1:0].
- An accept with HSIZE > 2, or with an address misaligned for its size, never reaches APB. It goes straight to ERR1.
- FSM states are IDLE, SETUP, ACCESS, DONE, ERR1, ERR2.
- IDLE: HREADYOUT=1, HRESP=0. A valid accept goes to SETUP; an invalid accept goes to ERR1.
- SETUP: PSEL=1, PENABLE=0, HREADYOUT=0. Always moves to ACCESS.
- ACCESS: PSEL=1, PENABLE=1, HREADYOUT=0.
  - PREADY & !PSLVERR: register HRDATA <= PRDATA on reads, then go to DONE.
  - PREADY & PSLVERR: go to ERR1.
  - Timeout counter reaches TIMEOUT (TIMEOUT ≠ 0): go to ERR1.
- DONE: HREADYOUT=1, HRESP=0, PSEL=0.
- ERR1: HREADYOUT=0, HRESP=1.
- ERR2: HREADYOUT=1, HRESP=1.
- ERR1 always moves to ERR2.
- DONE and ERR2 handle the next transfer the same way IDLE does (pipelined back-to-back), otherwise they return to IDLE.
- An accept observed in ERR1 (master did not cancel) is registered and serviced after ERR2.
- PWDATA is driven combinationally from HWDATA. The master holds HWDATA stable while HREADYOUT=0.
- PSTRB, writes only (0 on reads):
  - size 0: one bit at addr[1:0].
  - size 1: 2'b11 shifted by {addr[1],1'b0}.
  - size 2: 4'hF.
- HRDATA holds its last value outside DONE.

## Timing
- Reset values: state IDLE, HREADYOUT=1, HRESP=0, HRDATA=0, PSEL=0, PENABLE=0, PADDR=0, PWRITE=0, PSTRB=0, timeout counter 0.
- Assertion of HRESET mid-transfer drops PSEL/PENABLE immediately (asynchronous) and abandons the transfer.
- Address phase in cycle N. SETUP in N+1, ACCESS in N+2. With PREADY=1 in N+2, DONE is in N+3.
- Minimum of 2 wait states per transfer. Each PREADY-low cycle adds 1.
- Error response takes exactly 2 cycles: HRESP=1 in both, HREADYOUT low then high.
- Timeout counter:
  - clears on entry to SETUP and increments each ACCESS cycle with PREADY=0;
  - saturates, with no wrap;
  - width is $clog2(TIMEOUT+1).
- PADDR, PWRITE and PSTRB are stable from SETUP through the last ACCESS cycle.

## Structure
- Shared package ahblite_pkg holds the HTRANS encodings (IDLE/BUSY/NONSEQ/SEQ), HSIZE codes, HRESP OKAY/ERROR, and the bridge state enum.
- One combinational sub-module, ahblite_apb_strb: (HSIZE, addr[1:0], write) -> PSTRB plus a misaligned flag.

## Test plan
- Zero-wait write of 0xDEADBEEF, size 2, to 0x0010 -> PSEL in N+1, PENABLE in N+2, PSTRB=4'hF, PWDATA=0xDEADBEEF, HREADYOUT=1 in N+3, HRESP=0.
- Read 0x0004 with PREADY low for 3 cycles and PRDATA=0x12345678 -> 5 wait states, HRDATA=0x12345678 in DONE.
- Byte write to 0x0003 -> PSTRB=4'b1000. Halfword write to 0x0002 -> PSTRB=4'b1100. Halfword write to 0x0001 -> ERR1/ERR2 with no PSEL.
- PSLVERR=1 with PREADY=1 -> HRESP=1 for two cycles, HREADYOUT 0 then 1.
- TIMEOUT=4 with PREADY stuck low -> ERROR after 4 ACCESS cycles, PSEL drops.
- Back-to-back writes with the second accepted in DONE -> SETUP follows DONE with no IDLE cycle.
- HRESET asserted during ACCESS -> PSEL=0 and HREADYOUT=1 immediately.

Source files
------------

// File: rtl/ahblite_pkg.sv
// Shared AHB-Lite encodings and the AHB-to-APB bridge state type.
// Helper functions classify bridge states for output decoding.
package ahblite_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_ACCESS = 3'd2,
        ST_DONE   = 3'd3,
        ST_ERR1   = 3'd4,
        ST_ERR2   = 3'd5
    } bridge_state_e;

    // NONSEQ and SEQ carry real transfers; IDLE and BUSY never do.
    function automatic logic htrans_active(input logic [1:0] trans);
        logic act;
        case (trans)
            HTRANS_IDLE:   act = 1'b0;
            HTRANS_BUSY:   act = 1'b0;
            HTRANS_NONSEQ: act = 1'b1;
            HTRANS_SEQ:    act = 1'b1;
            default:       act = 1'b0;
        endcase
        return act;
    endfunction

    // States in which the bridge can take a new address phase.
    function automatic logic is_slot(input bridge_state_e st);
        logic slot;
        case (st)
            ST_IDLE, ST_DONE, ST_ERR2: slot = 1'b1;
            default:                   slot = 1'b0;
        endcase
        return slot;
    endfunction

    function automatic logic is_err(input bridge_state_e st);
        logic err;
        case (st)
            ST_ERR1, ST_ERR2: err = 1'b1;
            default:          err = 1'b0;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/ahblite_apb_strb.sv
// Byte-strobe generation for APB writes and alignment checking of the
// incoming AHB transfer size/address.
module ahblite_apb_strb
    import ahblite_pkg::*;
(
    input  logic [2:0] size,
    input  logic [1:0] addr,
    input  logic       write,
    output logic [3:0] strb,
    output logic       misaligned
);

    logic [3:0] strb_raw_s;

    // Lane mask per size; sizes above a word yield no lanes.
    always_comb begin
        strb_raw_s = 4'b0000;
        misaligned = 1'b0;
        case (size)
            HSIZE_BYTE: begin
                strb_raw_s = 4'b0001 << addr;
                misaligned = 1'b0;
            end
            HSIZE_HALF: begin
                strb_raw_s = 4'b0011 << {addr[1], 1'b0};
                misaligned = addr[0];
            end
            HSIZE_WORD: begin
                strb_raw_s = 4'b1111;
                misaligned = |addr;
            end
            default: begin
                strb_raw_s = 4'b0000;
                misaligned = 1'b0;
            end
        endcase
    end

    // Reads never assert strobes.
    always_comb begin
        if (write) begin
            strb = strb_raw_s;
        end else begin
            strb = 4'b0000;
        end
    end

endmodule

// File: rtl/ahblite_apb_bridge.sv
// AHB-Lite slave that turns single transfers into APB3/APB4 accesses, with a
// two-cycle ERROR response for bad transfers, PSLVERR and PREADY timeouts.
module ahblite_apb_bridge
    import ahblite_pkg::*;
#(
    parameter int PADDR_WIDTH = 16,
    parameter int TIMEOUT     = 255
) (
    input  logic                   HCLK,
    input  logic                   HRESET,
    input  logic                   HSEL,
    input  logic [31:0]            HADDR,
    input  logic [1:0]             HTRANS,
    input  logic [2:0]             HSIZE,
    input  logic                   HWRITE,
    input  logic [31:0]            HWDATA,
    input  logic                   HREADY,
    output logic                   HREADYOUT,
    output logic [31:0]            HRDATA,
    output logic                   HRESP,
    output logic [PADDR_WIDTH-1:0] PADDR,
    output logic                   PSEL,
    output logic                   PENABLE,
    output logic                   PWRITE,
    output logic [31:0]            PWDATA,
    output logic [3:0]             PSTRB,
    input  logic [31:0]            PRDATA,
    input  logic                   PREADY,
    input  logic                   PSLVERR
);

    localparam bit TO_EN = (TIMEOUT > 0);
    localparam int CNT_W = TO_EN ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W:0] TO_LIMIT = (CNT_W + 1)'(TIMEOUT);

    bridge_state_e          state_r;
    bridge_state_e          state_nxt_s;
    logic                   hready_r;
    logic                   hresp_r;
    logic                   psel_r;
    logic                   penable_r;
    logic [PADDR_WIDTH-1:0] paddr_r;
    logic                   pwrite_r;
    logic [3:0]             pstrb_r;
    logic [31:0]            hrdata_r;
    logic [CNT_W-1:0]       tcnt_r;
    logic [CNT_W:0]         tcnt_inc_s;
    logic                   pend_r;
    logic                   pend_bad_r;

    logic                   req_s;
    logic                   accept_s;
    logic                   load_s;
    logic                   misal_s;
    logic                   bad_s;
    logic                   timeout_s;
    logic [3:0]             strb_s;
    logic                   unused_s;

    ahblite_apb_strb u_strb (
        .size       (HSIZE),
        .addr       (HADDR[1:0]),
        .write      (HWRITE),
        .strb       (strb_s),
        .misaligned (misal_s)
    );

    assign unused_s   = ^HADDR[31:PADDR_WIDTH];

    assign req_s      = HSEL & htrans_active(HTRANS);
    assign accept_s   = req_s & HREADY & is_slot(state_r);
    // A request held by the master during ERR1 is captured so it survives ERR2.
    assign load_s     = accept_s | (req_s & (state_r == ST_ERR1));
    assign bad_s      = (HSIZE > HSIZE_WORD) | misal_s;
    assign tcnt_inc_s = {1'b0, tcnt_r} + {{CNT_W{1'b0}}, 1'b1};
    assign timeout_s  = TO_EN & ~PREADY & (tcnt_inc_s == TO_LIMIT);

    // Next-state decision for the transfer sequencer.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE, ST_ERR2: begin
                if (accept_s) begin
                    state_nxt_s = bad_s ? ST_ERR1 : ST_SETUP;
                end else if ((state_r == ST_ERR2) && pend_r) begin
                    state_nxt_s = pend_bad_r ? ST_ERR1 : ST_SETUP;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                state_nxt_s = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (PREADY) begin
                    state_nxt_s = PSLVERR ? ST_ERR1 : ST_DONE;
                end else if (timeout_s) begin
                    state_nxt_s = ST_ERR1;
                end else begin
                    state_nxt_s = ST_ACCESS;
                end
            end
            ST_ERR1: begin
                state_nxt_s = ST_ERR2;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register with bus handshake outputs decoded from the next state.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_r   <= ST_IDLE;
            hready_r  <= 1'b1;
            hresp_r   <= HRESP_OKAY;
            psel_r    <= 1'b0;
            penable_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            hready_r  <= is_slot(state_nxt_s);
            hresp_r   <= is_err(state_nxt_s) ? HRESP_ERROR : HRESP_OKAY;
            psel_r    <= (state_nxt_s == ST_SETUP) || (state_nxt_s == ST_ACCESS);
            penable_r <= (state_nxt_s == ST_ACCESS);
        end
    end

    // Address-phase capture; held constant through SETUP and ACCESS.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            paddr_r  <= {PADDR_WIDTH{1'b0}};
            pwrite_r <= 1'b0;
            pstrb_r  <= 4'b0000;
        end else if (load_s) begin
            paddr_r  <= HADDR[PADDR_WIDTH-1:0];
            pwrite_r <= HWRITE;
            pstrb_r  <= strb_s;
        end else begin
            paddr_r  <= paddr_r;
            pwrite_r <= pwrite_r;
            pstrb_r  <= pstrb_r;
        end
    end

    // Remember whether a request was pending in ERR1 and if it was legal.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            pend_r     <= 1'b0;
            pend_bad_r <= 1'b0;
        end else begin
            pend_r     <= req_s & (state_r == ST_ERR1);
            pend_bad_r <= bad_s;
        end
    end

    // PREADY-low counter for the current access; saturates instead of wrapping.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            tcnt_r <= {CNT_W{1'b0}};
        end else if (state_nxt_s == ST_SETUP) begin
            tcnt_r <= {CNT_W{1'b0}};
        end else if ((state_r == ST_ACCESS) && !PREADY && !(&tcnt_r)) begin
            tcnt_r <= tcnt_inc_s[CNT_W-1:0];
        end else begin
            tcnt_r <= tcnt_r;
        end
    end

    // Read data is updated only by a successful read completion.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            hrdata_r <= 32'h0000_0000;
        end else if ((state_r == ST_ACCESS) && PREADY && !PSLVERR && !pwrite_r) begin
            hrdata_r <= PRDATA;
        end else begin
            hrdata_r <= hrdata_r;
        end
    end

    assign HREADYOUT = hready_r;
    assign HRESP     = hresp_r;
    assign HRDATA    = hrdata_r;
    assign PSEL      = psel_r;
    assign PENABLE   = penable_r;
    assign PADDR     = paddr_r;
    assign PWRITE    = pwrite_r;
    assign PSTRB     = pstrb_r;
    assign PWDATA    = HWDATA;

endmodule

// File: tb/tb_ahblite_apb_bridge.sv
// Randomized self-checking bench for ahblite_apb_bridge: transfers are expanded
// into per-cycle expected bus behaviour and compared every cycle.
module tb_ahblite_apb_bridge;

    localparam int TO = 4;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic        HWRITE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HREADYOUT;
    logic [31:0] HRDATA;
    logic        HRESP;
    logic [15:0] PADDR;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic [3:0]  PSTRB;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    always #5 HCLK = ~HCLK;

    ahblite_apb_bridge #(.PADDR_WIDTH(16), .TIMEOUT(TO)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR),
        .HTRANS(HTRANS), .HSIZE(HSIZE), .HWRITE(HWRITE), .HWDATA(HWDATA),
        .HREADY(HREADY), .HREADYOUT(HREADYOUT), .HRDATA(HRDATA), .HRESP(HRESP),
        .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(PRDATA), .PREADY(PREADY),
        .PSLVERR(PSLVERR)
    );

    typedef struct {
        bit          xfer;
        bit          hsel;
        logic [1:0]  htrans;
        logic [31:0] haddr;
        logic [2:0]  hsize;
        bit          hwrite;
        logic [31:0] wdata;
        int          waits;
        bit          slverr;
        logic [31:0] rdata;
        bit          early;
        logic [4:0]  pin_strb;
        int          pin_wait;
    } item_t;

    item_t items[$];

    int checks = 0;
    int errors = 0;

    // per-cycle expectations, written by the stimulus, read by the compare process
    logic        e_hro, e_resp, e_psel, e_pen, e_pwrite;
    logic [15:0] e_paddr;
    logic [3:0]  e_pstrb;
    logic [31:0] e_pwdata, e_hrdata;
    bit          chk_en = 1'b0;
    bit          e_pin_strb_en = 1'b0;
    logic [3:0]  e_pin_strb;
    bit          e_pin_wait_en = 1'b0;
    int          e_pin_wait;
    int          low_run = 0;
    int          last_low_run = 0;

    // transaction-level model state
    logic [31:0] m_hrdata = 32'h0;
    bit          m_hro = 1'b1;
    bit          m_resp = 1'b0;
    int          m_pin_wait = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge HCLK) begin
        #2;
        if (HREADYOUT === 1'b0) begin
            low_run = low_run + 1;
        end else begin
            last_low_run = low_run;
            low_run = 0;
        end
        if (chk_en) begin
            chk("hreadyout", 32'(HREADYOUT), 32'(e_hro));
            chk("hresp", 32'(HRESP), 32'(e_resp));
            chk("psel", 32'(PSEL), 32'(e_psel));
            chk("penable", 32'(PENABLE), 32'(e_pen));
            chk("hrdata", HRDATA, e_hrdata);
            if (e_psel) begin
                chk("paddr", 32'(PADDR), 32'(e_paddr));
                chk("pwrite", 32'(PWRITE), 32'(e_pwrite));
                chk("pstrb", 32'(PSTRB), 32'(e_pstrb));
                if (e_pwrite) chk("pwdata", PWDATA, e_pwdata);
            end
            if (e_pin_strb_en) chk("pstrb_literal", 32'(PSTRB), 32'(e_pin_strb));
            if (e_pin_wait_en) chk("wait_states", 32'(last_low_run), 32'(e_pin_wait));
        end
    end

    function automatic bit ok_xfer(input logic [2:0] size, input logic [31:0] addr);
        return (size <= 3'd2) && ((addr % (32'd1 << size)) == 32'd0);
    endfunction

    function automatic logic [3:0] model_strb(input logic [2:0] size, input logic [31:0] addr,
                                              input bit wr);
        int nb;
        int m;
        if (!wr) return 4'b0000;
        nb = 1 << size;
        m = ((1 << nb) - 1) << (addr % 4);
        return m[3:0];
    endfunction

    function automatic item_t mk(input logic [31:0] addr, input logic [2:0] size, input bit wr,
                                 input logic [31:0] wd, input int waits, input bit serr,
                                 input logic [31:0] rd);
        item_t it;
        it.xfer = 1'b1; it.hsel = 1'b1; it.htrans = 2'b10; it.haddr = addr;
        it.hsize = size; it.hwrite = wr; it.wdata = wd; it.waits = waits;
        it.slverr = serr; it.rdata = rd; it.early = 1'b0; it.pin_strb = 5'h00;
        it.pin_wait = 0;
        return it;
    endfunction

    function automatic item_t mk_idle();
        item_t it;
        int k;
        it = mk(32'($urandom), 3'($urandom), 1'($urandom), 32'h0, 0, 1'b0, 32'h0);
        it.xfer = 1'b0;
        k = $urandom_range(0, 2);
        it.hsel = (k == 2) ? 1'b0 : 1'($urandom);
        it.htrans = (k == 0) ? 2'b00 : (k == 1) ? 2'b01 : 2'($urandom_range(2, 3));
        return it;
    endfunction

    task automatic set_exp(input bit hro, input bit resp, input bit psel, input bit pen);
        e_hro = hro; e_resp = resp; e_psel = psel; e_pen = pen;
        e_hrdata = m_hrdata;
        e_pin_strb_en = 1'b0;
        e_pin_wait_en = 1'b0;
        HREADY = hro;
        chk_en = 1'b1;
    endtask

    task automatic slot_exp();
        set_exp(m_hro, m_resp, 1'b0, 1'b0);
        if (m_pin_wait > 0) begin
            e_pin_wait_en = 1'b1;
            e_pin_wait = m_pin_wait;
            m_pin_wait = 0;
        end
    endtask

    task automatic drive_addr(input item_t it);
        HSEL = it.hsel; HTRANS = it.htrans; HADDR = it.haddr;
        HSIZE = it.hsize; HWRITE = it.hwrite;
    endtask

    task automatic drive_junk();
        HSEL = 1'($urandom); HTRANS = 2'($urandom); HADDR = $urandom;
        HSIZE = 3'($urandom); HWRITE = 1'($urandom);
    endtask

    task automatic drive_apb_idle();
        PREADY = 1'($urandom); PSLVERR = 1'($urandom); PRDATA = $urandom;
    endtask

    task automatic err1_cycle(input int j);
        @(negedge HCLK);
        set_exp(1'b0, 1'b1, 1'b0, 1'b0);
        drive_apb_idle();
        if ((j + 1 < items.size()) && items[j+1].xfer && items[j+1].early) begin
            drive_addr(items[j+1]);
        end else begin
            HSEL = 1'($urandom);
            HTRANS = 2'b00;
        end
        m_hro = 1'b1;
        m_resp = 1'b1;
    endtask

    task automatic run_item(input int j);
        item_t it;
        int nacc;
        it = items[j];
        @(negedge HCLK);
        slot_exp();
        drive_addr(it);
        drive_apb_idle();
        if (!it.xfer) begin
            m_hro = 1'b1; m_resp = 1'b0;
            return;
        end
        if (!ok_xfer(it.hsize, it.haddr)) begin
            err1_cycle(j);
            return;
        end
        @(negedge HCLK);
        set_exp(1'b0, 1'b0, 1'b1, 1'b0);
        e_paddr = it.haddr[15:0];
        e_pwrite = it.hwrite;
        e_pstrb = model_strb(it.hsize, it.haddr, it.hwrite);
        e_pwdata = it.wdata;
        HWDATA = it.wdata;
        if (it.pin_strb[4]) begin
            e_pin_strb_en = 1'b1;
            e_pin_strb = it.pin_strb[3:0];
        end
        drive_junk();
        drive_apb_idle();
        nacc = (it.waits >= TO) ? TO : it.waits + 1;
        for (int a = 0; a < nacc; a++) begin
            @(negedge HCLK);
            set_exp(1'b0, 1'b0, 1'b1, 1'b1);
            drive_junk();
            PREADY = (a == it.waits);
            PSLVERR = (a == it.waits) ? it.slverr : 1'($urandom);
            PRDATA = (a == it.waits) ? it.rdata : $urandom;
        end
        if ((it.waits >= TO) || it.slverr) begin
            err1_cycle(j);
        end else begin
            if (!it.hwrite) m_hrdata = it.rdata;
            m_hro = 1'b1; m_resp = 1'b0;
            m_pin_wait = it.pin_wait;
        end
    endtask

    task automatic run_all();
        for (int j = 0; j < items.size(); j++) run_item(j);
    endtask

    initial begin
        #1_000_000;
        errors++;
        $display("FAIL watchdog: actual still running required finished");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        item_t it;
        int r;
        HRESET = 1'b1; HSEL = 1'b0; HADDR = 32'h0; HTRANS = 2'b00; HSIZE = 3'd0;
        HWRITE = 1'b0; HWDATA = 32'h0; HREADY = 1'b1; PRDATA = 32'h0;
        PREADY = 1'b0; PSLVERR = 1'b0;
        @(negedge HCLK);
        @(negedge HCLK);
        chk("rst_hreadyout", 32'(HREADYOUT), 32'd1);
        chk("rst_hresp", 32'(HRESP), 32'd0);
        chk("rst_hrdata", HRDATA, 32'd0);
        chk("rst_psel", 32'(PSEL), 32'd0);
        chk("rst_penable", 32'(PENABLE), 32'd0);
        chk("rst_paddr", 32'(PADDR), 32'd0);
        chk("rst_pwrite", 32'(PWRITE), 32'd0);
        chk("rst_pstrb", 32'(PSTRB), 32'd0);
        HRESET = 1'b0;

        // directed scenarios
        it = mk(32'h0000_0010, 3'd2, 1'b1, 32'hDEADBEEF, 0, 1'b0, 32'h0);
        it.pin_strb = 5'h1F; items.push_back(it);
        items.push_back(mk_idle());
        it = mk(32'h0000_0004, 3'd2, 1'b0, 32'h0, 3, 1'b0, 32'h12345678);
        it.pin_wait = 5; items.push_back(it);
        it = mk(32'h0000_0003, 3'd0, 1'b1, 32'hAA00_0000, 0, 1'b0, 32'h0);
        it.pin_strb = 5'h18; items.push_back(it);
        it = mk(32'h0000_0002, 3'd1, 1'b1, 32'hBBBB_0000, 1, 1'b0, 32'h0);
        it.pin_strb = 5'h1C; items.push_back(it);
        items.push_back(mk(32'h0000_0001, 3'd1, 1'b1, 32'h1111_1111, 0, 1'b0, 32'h0));
        it = mk(32'h0000_0040, 3'd2, 1'b1, 32'hCAFE_F00D, 1, 1'b1, 32'h0);
        it.early = 1'b1; items.push_back(it);
        items.push_back(mk(32'h0000_0044, 3'd2, 1'b0, 32'h0, 6, 1'b0, 32'h5555_AAAA));
        items.push_back(mk(32'h0000_0050, 3'd2, 1'b1, 32'h0102_0304, 0, 1'b0, 32'h0));
        items.push_back(mk(32'h0000_0054, 3'd2, 1'b1, 32'h0506_0708, 0, 1'b0, 32'h0));
        run_all();

        // reset in the middle of an access
        @(negedge HCLK);
        slot_exp();
        drive_addr(mk(32'h0000_0020, 3'd2, 1'b0, 32'h0, 0, 1'b0, 32'h0));
        drive_apb_idle();
        @(negedge HCLK);
        set_exp(1'b0, 1'b0, 1'b1, 1'b0);
        e_paddr = 16'h0020; e_pwrite = 1'b0; e_pstrb = 4'h0;
        drive_junk();
        @(negedge HCLK);
        set_exp(1'b0, 1'b0, 1'b1, 1'b1);
        drive_junk();
        PREADY = 1'b0;
        #3;
        HRESET = 1'b1;
        chk_en = 1'b0;
        #1;
        chk("arst_psel", 32'(PSEL), 32'd0);
        chk("arst_penable", 32'(PENABLE), 32'd0);
        chk("arst_hreadyout", 32'(HREADYOUT), 32'd1);
        chk("arst_hresp", 32'(HRESP), 32'd0);
        chk("arst_hrdata", HRDATA, 32'd0);
        @(negedge HCLK);
        HSEL = 1'b0; HTRANS = 2'b00;
        @(negedge HCLK);
        HRESET = 1'b0;
        m_hrdata = 32'h0; m_hro = 1'b1; m_resp = 1'b0; m_pin_wait = 0;

        // randomized traffic
        items.delete();
        for (int n = 0; n < 250; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                items.push_back(mk_idle());
            end else begin
                r = $urandom_range(0, 9);
                it = mk($urandom, (r < 8) ? 3'(r % 3) : 3'($urandom_range(3, 7)),
                        1'($urandom), $urandom, $urandom_range(0, 6),
                        ($urandom_range(0, 5) == 0), $urandom);
                it.htrans = 2'($urandom_range(2, 3));
                it.early = 1'($urandom);
                if ((it.hsize <= 3'd2) && $urandom_range(0, 3) != 0)
                    it.haddr = it.haddr & ~((32'd1 << it.hsize) - 32'd1);
                items.push_back(it);
            end
        end
        run_all();

        @(negedge HCLK);
        slot_exp();
        HSEL = 1'b0; HTRANS = 2'b00;
        drive_apb_idle();
        @(negedge HCLK);
        chk_en = 1'b0;
        #5;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
